// File: rtl/mmio_xbar.sv
// mmio_xbar: table-driven MMIO interconnect between the CPU data port and
// NSLV slave regions. Decodes by base/mask (lowest index wins on overlap),
// holds one request at a time, waits for the selected slave's ack with a
// bounded timeout, and returns a one-cycle response strobe. Unmapped or
// dead addresses get an error response carrying ERR_DATA.
module mmio_xbar #(
  parameter int                     WIDTH    = 32,
  parameter int                     NSLV     = 4,
  parameter logic [NSLV*WIDTH-1:0]  BASE     = {NSLV{32'h0}},
  parameter logic [NSLV*WIDTH-1:0]  MASK     = {NSLV{32'h0}},
  parameter int                     TIMEOUT  = 16,
  parameter logic [WIDTH-1:0]       ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    m_valid,
  output logic                    m_ready,
  input  logic                    m_we,
  input  logic [WIDTH-1:0]        m_addr,
  input  logic [WIDTH-1:0]        m_wdata,
  input  logic [WIDTH/8-1:0]      m_be,
  output logic                    m_rvalid,
  output logic [WIDTH-1:0]        m_rdata,
  output logic                    m_err,
  output logic [7:0]              err_cnt,
  output logic [NSLV-1:0]         s_sel,
  output logic                    s_we,
  output logic [WIDTH-1:0]        s_wdata,
  output logic [WIDTH/8-1:0]      s_be,
  output logic [WIDTH-1:0]        s_addr,
  input  logic [NSLV-1:0]         s_ack,
  input  logic [NSLV*WIDTH-1:0]   s_rdata
);

  localparam int IW = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int CW = $clog2(TIMEOUT);
  localparam int BW = WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Address decode: returns {hit, index}; scanning downwards lets the
  // lowest matching index overwrite any higher one.
  function automatic logic [IW:0] decode(input logic [WIDTH-1:0] addr);
    logic [IW:0] r;
    r = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((addr & MASK[i*WIDTH +: WIDTH]) == BASE[i*WIDTH +: WIDTH]) begin
        r = {1'b1, IW'(i)};
      end
    end
    return r;
  endfunction

  state_t               state_q, state_d;
  logic                 we_q, we_d;
  logic [WIDTH-1:0]     addr_q, addr_d;
  logic [WIDTH-1:0]     wdata_q, wdata_d;
  logic [BW-1:0]        be_q, be_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic                 rvalid_q, rvalid_d;
  logic [NSLV-1:0]      sel_q, sel_d;
  logic [7:0]           err_cnt_q, err_cnt_d;
  logic [IW:0]          dec;

  // Next-state and response computation for the IDLE/ACCESS/RESP sequence.
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    err_cnt_d = err_cnt_q;
    rvalid_d  = 1'b0;
    rdata_d   = '0;
    err_d     = 1'b0;
    dec       = decode(m_addr);
    case (state_q)
      IDLE: begin
        if (m_valid) begin
          we_d    = m_we;
          addr_d  = m_addr;
          wdata_d = m_wdata;
          be_d    = m_be;
          idx_d   = dec[IW-1:0];
          if (dec[IW]) begin
            state_d = ACCESS;
            sel_d   = NSLV'(1) << dec[IW-1:0];
            cnt_d   = '0;
          end else begin
            state_d  = RESP;
            rvalid_d = 1'b1;
            rdata_d  = ERR_DATA;
            err_d    = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (s_ack[idx_q]) begin
          // Ack takes priority over a simultaneous timeout.
          state_d  = RESP;
          sel_d    = '0;
          rvalid_d = 1'b1;
          rdata_d  = we_q ? '0 : s_rdata[int'(idx_q)*WIDTH +: WIDTH];
          err_d    = 1'b0;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d  = RESP;
          sel_d    = '0;
          rvalid_d = 1'b1;
          rdata_d  = ERR_DATA;
          err_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
        if (err_q && (err_cnt_q != 8'hFF)) begin
          err_cnt_d = err_cnt_q + 8'd1;
        end else begin
          err_cnt_d = err_cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
      end
    endcase
  end

  // State and latched request/response registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      rvalid_q  <= 1'b0;
      sel_q     <= '0;
      err_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      rvalid_q  <= rvalid_d;
      sel_q     <= sel_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign m_ready  = (state_q == IDLE);
  assign m_rvalid = rvalid_q;
  assign m_rdata  = rdata_q;
  assign m_err    = err_q;
  assign err_cnt  = err_cnt_q;
  assign s_sel    = sel_q;
  assign s_we     = we_q;
  assign s_wdata  = wdata_q;
  assign s_be     = be_q;
  // Offset within the region: strip the decoded bits of the latched address.
  assign s_addr   = addr_q & ~MASK[int'(idx_q)*WIDTH +: WIDTH];

endmodule

// File: tb/tb_mmio_xbar.sv
// Testbench for mmio_xbar: directed scenarios plus randomized transactions
// checked against a transaction-level reference model.
module tb_mmio_xbar;
  localparam int W  = 32;
  localparam int N  = 4;
  localparam int TO = 16;
  // {slave3, slave2, slave1, slave0}; slave 2 lies inside slave 0's region.
  localparam logic [N*W-1:0] BASE_P = {32'h4000_0000, 32'h2000_0000, 32'h0000_1000, 32'h2000_0000};
  localparam logic [N*W-1:0] MASK_P = {32'hF000_0000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_0000};

  logic clk, rst, m_valid, m_ready, m_we, m_rvalid, m_err, s_we;
  logic [W-1:0] m_addr, m_wdata, m_rdata, s_wdata, s_addr;
  logic [3:0] m_be, s_be;
  logic [7:0] err_cnt;
  logic [N-1:0] s_sel, s_ack;
  logic [N*W-1:0] s_rdata;

  mmio_xbar #(.WIDTH(W), .NSLV(N), .BASE(BASE_P), .MASK(MASK_P), .TIMEOUT(TO),
              .ERR_DATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .rst(rst), .m_valid(m_valid), .m_ready(m_ready), .m_we(m_we),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be), .m_rvalid(m_rvalid),
    .m_rdata(m_rdata), .m_err(m_err), .err_cnt(err_cnt), .s_sel(s_sel),
    .s_we(s_we), .s_wdata(s_wdata), .s_be(s_be), .s_addr(s_addr),
    .s_ack(s_ack), .s_rdata(s_rdata));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: region table and error counter.
  logic [31:0] mdl_base [N] = '{32'h2000_0000, 32'h0000_1000, 32'h2000_0000, 32'h4000_0000};
  logic [31:0] mdl_mask [N] = '{32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hF000_0000};
  int exp_err_cnt = 0;
  int exp_idx, exp_sel_cycles, exp_lat;
  logic [31:0] exp_rdata, exp_saddr;
  logic exp_err;

  // Observations from the last transaction.
  int obs_sel_cycles, obs_lat;
  logic [N-1:0] obs_sel_or;
  logic obs_sel_bad, obs_leak, obs_timeout, obs_ready_before, obs_ready_after, obs_swe, obs_err;
  logic [31:0] obs_saddr, obs_swdata, obs_rdata;
  logic [3:0] obs_sbe;
  logic [7:0] obs_errcnt;

  // Model: first matching region wins; a slave has TO cycles to answer.
  task automatic model_txn(input logic we, input logic [31:0] addr, input int ack_at, input logic [31:0] rd);
    exp_idx = -1;
    for (int i = N - 1; i >= 0; i--)
      if ((addr & mdl_mask[i]) == mdl_base[i]) exp_idx = i;
    if (exp_idx < 0) begin
      exp_sel_cycles = 0; exp_lat = 1; exp_err = 1'b1; exp_rdata = 32'hDEAD_BEEF; exp_saddr = 32'h0;
    end else begin
      exp_saddr = addr & ~mdl_mask[exp_idx];
      if (ack_at <= TO) begin
        exp_sel_cycles = ack_at; exp_lat = ack_at + 1; exp_err = 1'b0;
        exp_rdata = we ? 32'h0 : rd;
      end else begin
        exp_sel_cycles = TO; exp_lat = TO + 1; exp_err = 1'b1; exp_rdata = 32'hDEAD_BEEF;
      end
    end
    if (exp_err && exp_err_cnt < 255) exp_err_cnt++;
  endtask

  // Drive one request and act as the slaves; ack is given on sel cycle ack_at.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input int ack_at, input logic [31:0] rd);
    logic [N-1:0] noise;
    obs_ready_before = m_ready;
    m_valid = 1'b1; m_we = we; m_addr = addr; m_wdata = wdata; m_be = be;
    @(posedge clk);
    @(negedge clk);
    m_valid = 1'b0; m_we = ~we; m_addr = $urandom; m_wdata = $urandom; m_be = 4'($urandom);
    obs_sel_cycles = 0; obs_lat = 0; obs_sel_or = '0; obs_sel_bad = 1'b0; obs_leak = 1'b0;
    obs_timeout = 1'b0; obs_saddr = '0; obs_swe = 1'b0; obs_swdata = '0; obs_sbe = '0;
    obs_rdata = '0; obs_err = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (s_sel != '0) begin
        obs_sel_cycles++;
        if (obs_sel_cycles == 1) begin
          obs_saddr = s_addr; obs_swe = s_we; obs_swdata = s_wdata; obs_sbe = s_be;
        end
        if (!$onehot(s_sel)) obs_sel_bad = 1'b1;
        obs_sel_or = obs_sel_or | s_sel;
      end
      if (m_rvalid) begin
        obs_lat = c; obs_rdata = m_rdata; obs_err = m_err;
        break;
      end
      if (m_rdata !== 32'h0 || m_err !== 1'b0) obs_leak = 1'b1;
      noise = N'($urandom) & ~s_sel;
      s_ack = (s_sel != '0 && obs_sel_cycles == ack_at) ? (s_sel | noise) : noise;
      s_rdata = {$urandom, $urandom, $urandom, $urandom};
      for (int k = 0; k < N; k++) if (s_sel[k]) s_rdata[k*W +: W] = rd;
      @(negedge clk);
    end
    s_ack = '0;
    if (obs_lat == 0) obs_timeout = 1'b1;
    @(negedge clk);
    obs_ready_after = m_ready;
    obs_errcnt = err_cnt;
  endtask

  task automatic test_reset;
    rst = 1'b1; m_valid = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_be = '0;
    s_ack = '0; s_rdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({m_rvalid, m_rdata, m_err, err_cnt, s_sel, s_we, s_wdata, s_be, s_addr} !== '0) begin
      errors++; $display("FAIL reset_outputs: got rv=%b rd=%h err=%b cnt=%0d sel=%b addr=%h, expected all 0",
                         m_rvalid, m_rdata, m_err, err_cnt, s_sel, s_addr);
    end
    checks++;
    if (m_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", m_ready); end
    exp_err_cnt = 0;
  endtask

  task automatic test_zero_wait_read;
    model_txn(1'b0, 32'h1004, 1, 32'h1234_5678);
    run_txn(1'b0, 32'h1004, 32'h0, 4'hF, 1, 32'h1234_5678);
    checks++;
    if (obs_saddr !== 32'h004) begin errors++; $display("FAIL zw_saddr: got %h expected 004", obs_saddr); end
    checks++;
    if (obs_lat !== 2) begin errors++; $display("FAIL zw_latency: got %0d expected 2", obs_lat); end
    checks++;
    if (obs_rdata !== 32'h1234_5678 || obs_err !== 1'b0) begin
      errors++; $display("FAIL zw_resp: got %h/%b expected 12345678/0", obs_rdata, obs_err);
    end
    checks++;
    if (obs_sel_or !== 4'b0010 || obs_sel_cycles !== 1) begin
      errors++; $display("FAIL zw_sel: got %b x%0d expected 0010 x1", obs_sel_or, obs_sel_cycles);
    end
    checks++;
    if (obs_ready_after !== 1'b1) begin errors++; $display("FAIL zw_ready: got %b expected 1", obs_ready_after); end
  endtask

  task automatic test_wait_states;
    model_txn(1'b1, 32'h1008, 5, 32'h5555_5555);
    run_txn(1'b1, 32'h1008, 32'hA5A5_A5A5, 4'b0011, 5, 32'h5555_5555);
    checks++;
    if (obs_sel_cycles !== 5) begin errors++; $display("FAIL ws_sel_cycles: got %0d expected 5", obs_sel_cycles); end
    checks++;
    if (obs_sbe !== 4'b0011 || obs_swe !== 1'b1 || obs_swdata !== 32'hA5A5_A5A5 || obs_saddr !== 32'h008) begin
      errors++; $display("FAIL ws_fields: got be=%b we=%b wd=%h a=%h expected 0011/1/a5a5a5a5/008",
                         obs_sbe, obs_swe, obs_swdata, obs_saddr);
    end
    checks++;
    if (obs_rdata !== 32'h0 || obs_err !== 1'b0 || obs_lat !== 6) begin
      errors++; $display("FAIL ws_resp: got %h/%b lat %0d expected 0/0 lat 6", obs_rdata, obs_err, obs_lat);
    end
  endtask

  task automatic test_timeout;
    model_txn(1'b0, 32'h1010, 1000, 32'h1111_2222);
    run_txn(1'b0, 32'h1010, 32'h0, 4'hF, 1000, 32'h1111_2222);
    checks++;
    if (obs_sel_cycles !== 16) begin errors++; $display("FAIL to_sel_cycles: got %0d expected 16", obs_sel_cycles); end
    checks++;
    if (obs_err !== 1'b1 || obs_rdata !== 32'hDEAD_BEEF || obs_lat !== 17) begin
      errors++; $display("FAIL to_resp: got %b/%h lat %0d expected 1/deadbeef lat 17", obs_err, obs_rdata, obs_lat);
    end
    checks++;
    if (obs_errcnt !== 8'd1) begin errors++; $display("FAIL to_errcnt: got %0d expected 1", obs_errcnt); end
    model_txn(1'b0, 32'h1014, 16, 32'h3333_4444);
    run_txn(1'b0, 32'h1014, 32'h0, 4'hF, 16, 32'h3333_4444);
    checks++;
    if (obs_err !== 1'b0 || obs_rdata !== 32'h3333_4444 || obs_sel_cycles !== 16) begin
      errors++; $display("FAIL to_ack16: got %b/%h x%0d expected 0/33334444 x16", obs_err, obs_rdata, obs_sel_cycles);
    end
  endtask

  task automatic test_unmapped_overlap;
    model_txn(1'b0, 32'h8000_0000, 1, 32'h0);
    run_txn(1'b0, 32'h8000_0000, 32'h0, 4'hF, 1, 32'h0);
    checks++;
    if (obs_lat !== 1 || obs_err !== 1'b1 || obs_sel_cycles !== 0 || obs_rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL unmapped: got lat %0d err %b sel x%0d rd %h expected 1/1/0/deadbeef",
                         obs_lat, obs_err, obs_sel_cycles, obs_rdata);
    end
    checks++;
    if (obs_ready_after !== 1'b1 || obs_errcnt !== 8'(exp_err_cnt)) begin
      errors++; $display("FAIL unmapped_after: got rdy %b cnt %0d expected 1/%0d", obs_ready_after, obs_errcnt, exp_err_cnt);
    end
    model_txn(1'b0, 32'h2000_0100, 2, 32'hCAFE_F00D);
    run_txn(1'b0, 32'h2000_0100, 32'h0, 4'hF, 2, 32'hCAFE_F00D);
    checks++;
    if (obs_sel_or !== 4'b0001 || obs_saddr !== 32'h0000_0100 || obs_rdata !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL overlap: got sel %b a %h rd %h expected 0001/00000100/cafef00d",
                         obs_sel_or, obs_saddr, obs_rdata);
    end
  endtask

  task automatic test_random;
    logic we; logic [31:0] addr, wd, rd; logic [3:0] be; int ack_at;
    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 3))
        0: addr = 32'h0000_1000 | ($urandom & 32'h0000_0FFF);
        1: addr = 32'h2000_0000 | ($urandom & 32'h0000_FFFF);
        2: addr = 32'h4000_0000 | ($urandom & 32'h0FFF_FFFF);
        default: addr = $urandom;
      endcase
      we = 1'($urandom); wd = $urandom; rd = $urandom; be = 4'($urandom);
      ack_at = $urandom_range(1, 20);
      model_txn(we, addr, ack_at, rd);
      run_txn(we, addr, wd, be, ack_at, rd);
      checks++;
      if (obs_timeout || obs_lat !== exp_lat || obs_err !== exp_err || obs_rdata !== exp_rdata) begin
        errors++; $display("FAIL rnd_resp[%0d]: got lat %0d err %b rd %h expected lat %0d err %b rd %h",
                           t, obs_lat, obs_err, obs_rdata, exp_lat, exp_err, exp_rdata);
      end
      checks++;
      if (obs_sel_cycles !== exp_sel_cycles || obs_sel_bad ||
          (exp_idx >= 0 && obs_sel_or !== 4'(1 << exp_idx))) begin
        errors++; $display("FAIL rnd_sel[%0d]: got %b x%0d expected idx %0d x%0d",
                           t, obs_sel_or, obs_sel_cycles, exp_idx, exp_sel_cycles);
      end
      if (exp_idx >= 0) begin
        checks++;
        if (obs_saddr !== exp_saddr || obs_swe !== we || obs_swdata !== wd || obs_sbe !== be) begin
          errors++; $display("FAIL rnd_fields[%0d]: got a %h we %b wd %h be %b expected %h %b %h %b",
                             t, obs_saddr, obs_swe, obs_swdata, obs_sbe, exp_saddr, we, wd, be);
        end
      end
      checks++;
      if (obs_leak || obs_ready_before !== 1'b1 || obs_ready_after !== 1'b1 || obs_errcnt !== 8'(exp_err_cnt)) begin
        errors++; $display("FAIL rnd_misc[%0d]: got leak %b rdy %b/%b cnt %0d expected 0 1/1 %0d",
                           t, obs_leak, obs_ready_before, obs_ready_after, obs_errcnt, exp_err_cnt);
      end
    end
  endtask

  task automatic test_reset_mid_access;
    logic seen_rv;
    m_valid = 1'b1; m_we = 1'b0; m_addr = 32'h1020; m_be = 4'hF;
    @(posedge clk);
    @(negedge clk);
    m_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (s_sel !== 4'b0010) begin errors++; $display("FAIL rst_mid_pre: got sel %b expected 0010", s_sel); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (s_sel !== 4'b0000) begin errors++; $display("FAIL rst_mid_sel: got %b expected 0000", s_sel); end
    rst = 1'b0;
    exp_err_cnt = 0;
    seen_rv = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (m_rvalid) seen_rv = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen_rv !== 1'b0 || m_ready !== 1'b1 || err_cnt !== 8'd0) begin
      errors++; $display("FAIL rst_mid_quiet: got rv %b rdy %b cnt %0d expected 0/1/0", seen_rv, m_ready, err_cnt);
    end
    model_txn(1'b0, 32'h1024, 3, 32'h0BAD_CAFE);
    run_txn(1'b0, 32'h1024, 32'h0, 4'hF, 3, 32'h0BAD_CAFE);
    checks++;
    if (obs_err !== 1'b0 || obs_rdata !== 32'h0BAD_CAFE || obs_lat !== 4) begin
      errors++; $display("FAIL rst_mid_next: got %b/%h lat %0d expected 0/0badcafe lat 4", obs_err, obs_rdata, obs_lat);
    end
  endtask

  task automatic test_saturation;
    for (int t = 0; t < 300; t++) begin
      model_txn(1'b0, 32'h8000_0000 + 32'(t), 1, 32'h0);
      run_txn(1'b0, 32'h8000_0000 + 32'(t), 32'h0, 4'h0, 1, 32'h0);
      checks++;
      if (obs_err !== 1'b1 || obs_errcnt !== 8'(exp_err_cnt)) begin
        errors++; $display("FAIL sat_step[%0d]: got err %b cnt %0d expected 1/%0d", t, obs_err, obs_errcnt, exp_err_cnt);
      end
    end
    checks++;
    if (err_cnt !== 8'd255) begin errors++; $display("FAIL sat_final: got %0d expected 255", err_cnt); end
  endtask

  initial begin
    test_reset();
    test_zero_wait_read();
    test_wait_states();
    test_timeout();
    test_unmapped_overlap();
    test_random();
    test_reset_mid_access();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_xbar.md
# mmio_xbar

Parametrised memory-mapped I/O interconnect between the CPU data port and NSLV slave regions (DRAM, seven-segment, buttons, VGA framebuffer, future peripherals). It replaces the fixed address comparisons of the previous memory wrapper with table-driven base/mask decoding, a valid/ready request handshake, per-slave acknowledge with wait states, a bus timeout, and error responses for unmapped or dead addresses. It sits between the core's MEM stage and the device modules.

## Interface
- WIDTH, 32, data and address width; must be a multiple of 8
- NSLV, 4, number of slave channels, 1..8
- BASE, {NSLV{32'h0}}, packed NSLV×WIDTH base addresses; slave i uses bits [i*WIDTH +: WIDTH]
- MASK, {NSLV{32'h0}}, packed NSLV×WIDTH decode masks; set bits are compared
- TIMEOUT, 16, number of cycles s_sel is held without an ack before an error; must be ≥2
- ERR_DATA, 32'hDEAD_BEEF, value of m_rdata on an error response

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- m_valid  in  1  request valid
- m_ready  out  1  request accepted when high together with m_valid
- m_we  in  1  1 = write, 0 = read
- m_addr  in  WIDTH  byte address
- m_wdata  in  WIDTH  write data
- m_be  in  WIDTH/8  byte enables
- m_rvalid  out  1  one-cycle response strobe, for both reads and writes
- m_rdata  out  WIDTH  read data, valid while m_rvalid is high
- m_err  out  1  error flag, qualified by m_rvalid
- err_cnt  out  8  count of error responses; saturates at 255
- s_sel  out  NSLV  one-hot slave select
- s_we, s_wdata, s_be  out  1/WIDTH/WIDTH/8  latched request fields
- s_addr  out  WIDTH  offset address, equal to m_addr & ~MASK[i]
- s_ack  in  NSLV  per-slave completion
- s_rdata  in  NSLV×WIDTH  packed per-slave read data, valid while the matching s_ack is high

## Operation
- **Decode:** slave i hits when (m_addr & MASK[i]) == BASE[i]. If regions overlap, the lowest index wins. No hit means the address is unmapped.
- **States:** IDLE, ACCESS, RESP.
- **m_ready:** equals (state == IDLE). It is combinational from the state register only.
- **IDLE:** on m_valid & m_ready, latch we/addr/wdata/be and the decoded index.
  - Hit: go to ACCESS and clear the timeout counter.
  - Miss: go to RESP with err = 1 and rdata = ERR_DATA.
- **ACCESS:** s_sel[idx] = 1. All other s_sel bits are 0. s_* fields hold the latched values.
  - s_ack[idx] sampled high: capture s_rdata[idx] on a read, or 0 on a write. Set err = 0 and go to RESP.
  - Otherwise the counter increments. When counter == TIMEOUT−1 with no ack: go to RESP with err = 1 and rdata = ERR_DATA.
  - If ack and timeout occur at the same edge, the ack wins.
  - s_ack from non-selected slaves is ignored in every state.
- **RESP:** m_rvalid = 1 for exactly one cycle, with m_rdata and m_err from the registers. Go to IDLE. If err is set, increment err_cnt unless it is at 255.
- **m_be = 0:** still forwarded as a normal transaction.
- **Outputs outside RESP:** m_rdata and m_err are 0 whenever m_rvalid is 0.

## Timing
- **Reset:** state = IDLE, counter = 0, err_cnt = 0, s_sel = 0, s_* = 0, m_rvalid = 0, m_rdata = 0, m_err = 0. m_ready is 1 in the first cycle after the reset edge.
- **Reset mid-transaction:** abandons the transaction. No m_rvalid is issued, and s_sel drops at the reset edge.
- **Mapped access:** accept at edge E0; s_sel is high during E0→E1. If ack is seen at E1, m_rvalid is high during E1→E2 and m_ready returns after E2. Minimum period is 3 cycles per transaction.
- **Each wait state** adds one cycle. s_sel is high for at most TIMEOUT cycles.
- **Unmapped access:** accept at E0, m_rvalid during E0→E1, m_ready after E1.
- **All outputs are registered**, except m_ready and s_addr.
- **s_addr** is combinational from the latched address and latched index.

## Test plan
- **Reset:** hold rst for 2 cycles. Check all outputs are 0 and m_ready = 1 in the cycle after reset.
- **Zero-wait read:** BASE[1] = 0x1000, MASK[1] = 0xFFFF_F000. Read 0x1004 with s_ack[1] high immediately and s_rdata[1] = 0x1234_5678. Require s_addr = 0x004, m_rvalid two cycles after accept, m_rdata = 0x1234_5678, m_err = 0.
- **Wait states:** write 0x1008, data 0xA5A5_A5A5, m_be = 4'b0011, ack after 5 cycles. Require s_sel[1] high for 5 cycles, s_be = 0011, then m_rvalid with m_rdata = 0, m_err = 0.
- **Timeout:** TIMEOUT = 16, slave never acks. Require s_sel high for exactly 16 cycles, then m_rvalid with m_err = 1, m_rdata = 0xDEAD_BEEF, err_cnt = 1. Repeat with ack on the 16th cycle: require no error.
- **Unmapped and overlap:** read 0x8000_0000 → m_rvalid on the next cycle with m_err = 1 and no s_sel pulse. With slaves 0 and 2 overlapping, require s_sel = 3'b001.
- **Reset mid-ACCESS and saturation:** pulse rst during ACCESS → no m_rvalid, and the next request succeeds. Then issue 300 unmapped reads → err_cnt = 255.
